// File: rtl/cv32e40p_rf_recovery_pkg.sv
// Shared types and sizes for the register-file recovery sequencer.
package cv32e40p_rf_recovery_pkg;

  localparam int RF_ADDR_W = 6;
  localparam int NREG_INT  = 32;
  localparam int NREG_FP   = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETBACK,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } rf_rec_state_e;

endpackage

// File: rtl/cv32e40p_rf_recovery.sv
// Restores the core register file from the golden copy, two registers per cycle.
// Define CV32E40P_RF_RECOVERY_FP_EN to also restore the FP registers f0-f31 (addr 32-63).
//
// state   | meaning
// IDLE    | waiting for start_i
// SETBACK | one cycle of core setback
// READ    | golden copy read of pair cnt/cnt+1
// DRAIN   | last write pair, no read
// DONE    | one-cycle done_o pulse
module cv32e40p_rf_recovery
  import cv32e40p_rf_recovery_pkg::*;
#(
  parameter bit RECOVER_X0 = 1'b0
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 setback_o,
  output logic                 recover_o,
  output logic                 backup_o,
  output logic [RF_ADDR_W-1:0] raddr_a_o,
  output logic [RF_ADDR_W-1:0] raddr_b_o,
  input  logic [31:0]          bkp_rdata_a_i,
  input  logic [31:0]          bkp_rdata_b_i,
  output logic                 we_a_o,
  output logic                 we_b_o,
  output logic [RF_ADDR_W-1:0] waddr_a_o,
  output logic [RF_ADDR_W-1:0] waddr_b_o,
  output logic [31:0]          wdata_a_o,
  output logic [31:0]          wdata_b_o
);

`ifdef CV32E40P_RF_RECOVERY_FP_EN
  localparam int NREG = NREG_INT + NREG_FP;
`else
  localparam int NREG = NREG_INT;
`endif
  localparam logic [RF_ADDR_W-1:0] CNT_LAST = RF_ADDR_W'(NREG - 2);

  rf_rec_state_e        state_q, state_d;
  logic [RF_ADDR_W-1:0] cnt_q;
  logic                 we_a_q, we_b_q;
  logic [RF_ADDR_W-1:0] waddr_a_q, waddr_b_q;
  logic                 read_cycle;

  assign read_cycle = (state_q == ST_READ);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start_i) state_d = ST_SETBACK;
      ST_SETBACK: state_d = ST_READ;
      ST_READ:    if (cnt_q == CNT_LAST) state_d = ST_DRAIN;
      ST_DRAIN:   state_d = ST_DONE;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o    = (state_q != ST_IDLE);
    done_o    = (state_q == ST_DONE);
    setback_o = (state_q == ST_SETBACK);
    recover_o = (state_q == ST_SETBACK) || (state_q == ST_READ) || (state_q == ST_DRAIN);
    backup_o  = read_cycle;
    raddr_a_o = read_cycle ? cnt_q : '0;
    raddr_b_o = read_cycle ? cnt_q + RF_ADDR_W'(1) : '0;
  end

  // Terminal compare clears the counter instead of letting it wrap.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (read_cycle && (cnt_q != CNT_LAST)) begin
      cnt_q <= cnt_q + RF_ADDR_W'(2);
    end else begin
      cnt_q <= '0;
    end
  end

  // Write stage trails the read by one cycle to match the golden-copy read latency.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_a_q    <= 1'b0;
      we_b_q    <= 1'b0;
      waddr_a_q <= '0;
      waddr_b_q <= '0;
    end else begin
      we_a_q    <= read_cycle && (RECOVER_X0 || (cnt_q != '0));
      we_b_q    <= read_cycle;
      waddr_a_q <= read_cycle ? cnt_q : '0;
      waddr_b_q <= read_cycle ? cnt_q + RF_ADDR_W'(1) : '0;
    end
  end

  assign we_a_o    = we_a_q;
  assign we_b_o    = we_b_q;
  assign waddr_a_o = waddr_a_q;
  assign waddr_b_o = waddr_b_q;
  assign wdata_a_o = we_a_q ? bkp_rdata_a_i : '0;
  assign wdata_b_o = we_b_q ? bkp_rdata_b_i : '0;

endmodule

// File: tb/tb_cv32e40p_rf_recovery.sv
// Self-checking bench: two instances (RECOVER_X0=0/1) against a cycle-position model.
module tb_cv32e40p_rf_recovery;

`ifdef CV32E40P_RF_RECOVERY_FP_EN
  localparam int NREG = 64;
`else
  localparam int NREG = 32;
`endif
  localparam int NR = NREG / 2;

  logic clk, rst_n, start;

  logic        busy0, done0, setback0, recover0, backup0, we_a0, we_b0;
  logic [5:0]  raddr_a0, raddr_b0, waddr_a0, waddr_b0;
  logic [31:0] rd_a0, rd_b0, wdata_a0, wdata_b0;
  logic        busy1, done1, setback1, recover1, backup1, we_a1, we_b1;
  logic [5:0]  raddr_a1, raddr_b1, waddr_a1, waddr_b1;
  logic [31:0] rd_a1, rd_b1, wdata_a1, wdata_b1;

  logic [31:0] mem [64];
  int k;
  int num_tests, num_fail;
  bit checking;

  cv32e40p_rf_recovery #(.RECOVER_X0(1'b0)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .busy_o(busy0), .done_o(done0), .setback_o(setback0), .recover_o(recover0),
    .backup_o(backup0), .raddr_a_o(raddr_a0), .raddr_b_o(raddr_b0),
    .bkp_rdata_a_i(rd_a0), .bkp_rdata_b_i(rd_b0),
    .we_a_o(we_a0), .we_b_o(we_b0), .waddr_a_o(waddr_a0), .waddr_b_o(waddr_b0),
    .wdata_a_o(wdata_a0), .wdata_b_o(wdata_b0)
  );

  cv32e40p_rf_recovery #(.RECOVER_X0(1'b1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start),
    .busy_o(busy1), .done_o(done1), .setback_o(setback1), .recover_o(recover1),
    .backup_o(backup1), .raddr_a_o(raddr_a1), .raddr_b_o(raddr_b1),
    .bkp_rdata_a_i(rd_a1), .bkp_rdata_b_i(rd_b1),
    .we_a_o(we_a1), .we_b_o(we_b1), .waddr_a_o(waddr_a1), .waddr_b_o(waddr_b1),
    .wdata_a_o(wdata_a1), .wdata_b_o(wdata_b1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Golden copy: one-cycle read latency.
  always @(posedge clk) begin
    rd_a0 <= mem[raddr_a0];
    rd_b0 <= mem[raddr_b0];
    rd_a1 <= mem[raddr_a1];
    rd_b1 <= mem[raddr_b1];
  end

  // k = cycles since the accepted start (0 = idle).
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) k = 0;
    else if (k == 0) begin
      if (start) k = 1;
    end else if (k == NR + 3) k = 0;
    else k = k + 1;
  end

  wire [95:0] obs0 = {1'b0, busy0, done0, setback0, recover0, backup0, raddr_a0, raddr_b0,
                      we_a0, we_b0, waddr_a0, waddr_b0, wdata_a0, wdata_b0};
  wire [95:0] obs1 = {1'b0, busy1, done1, setback1, recover1, backup1, raddr_a1, raddr_b1,
                      we_a1, we_b1, waddr_a1, waddr_b1, wdata_a1, wdata_b1};

  function automatic logic [95:0] model_vec(int kk, bit x0);
    logic rd, wr, wea;
    logic [5:0] ra, rb, wa, wb;
    logic [31:0] da, db;
    rd  = (kk >= 2) && (kk <= NR + 1);
    wr  = (kk >= 3) && (kk <= NR + 2);
    ra  = rd ? 6'(2 * (kk - 2)) : 6'd0;
    rb  = rd ? ra + 6'd1 : 6'd0;
    wa  = wr ? 6'(2 * (kk - 3)) : 6'd0;
    wb  = wr ? wa + 6'd1 : 6'd0;
    wea = wr && (x0 || (wa != 6'd0));
    da  = wea ? mem[wa] : 32'd0;
    db  = wr ? mem[wb] : 32'd0;
    return {1'b0, kk != 0, kk == NR + 3, kk == 1, (kk >= 1) && (kk <= NR + 2), rd, ra, rb,
            wea, wr, wa, wb, da, db};
  endfunction

  always @(negedge clk) begin
    if (checking) begin
      num_tests++;
      if (obs0 !== model_vec(k, 1'b0)) begin
        num_fail++;
        $display("FAIL cmp_dut0 k=%0d actual=%h required=%h", k, obs0, model_vec(k, 1'b0));
      end
      num_tests++;
      if (obs1 !== model_vec(k, 1'b1)) begin
        num_fail++;
        $display("FAIL cmp_dut1 k=%0d actual=%h required=%h", k, obs1, model_vec(k, 1'b1));
      end
    end
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    num_tests++;
    if (act !== exp) begin
      num_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic fill_mem(input bit pattern);
    for (int i = 0; i < 64; i++) mem[i] = pattern ? 32'hA5A5_0000 + 32'(i) : $urandom;
  endtask

  initial begin
    int we_seen;
    num_tests = 0;
    num_fail  = 0;
    checking  = 1'b0;
    rst_n = 1'b0;
    start = 1'b0;
    fill_mem(1'b1);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_dut0", obs0, 96'd0);
    chk("reset_dut1", obs1, 96'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    checking = 1'b1;

    // Single start pulse with the address-tagged golden copy
    start = 1'b1;
    for (int c = 1; c <= NR + 4; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) begin
        chk("setback_c1", 96'(setback0), 96'd1);
        start = 1'b0;
      end
      if (c == 2) begin
        chk("setback_c2", 96'(setback0), 96'd0);
        chk("raddr_a_c2", 96'(raddr_a0), 96'd0);
        chk("raddr_b_c2", 96'(raddr_b0), 96'd1);
      end
      if (c == 3) begin
        chk("we_a_x0_c3", 96'(we_a0), 96'd0);
        chk("we_b_c3", 96'(we_b0), 96'd1);
        chk("waddr_b_c3", 96'(waddr_b0), 96'd1);
        chk("wdata_b_c3", 96'(wdata_b0), 96'h A5A5_0001);
        chk("we_a_rx0_c3", 96'(we_a1), 96'd1);
        chk("waddr_a_rx0_c3", 96'(waddr_a1), 96'd0);
      end
      if (c == NR + 1) begin
        chk("last_raddr_a", 96'(raddr_a0), 96'(NREG - 2));
        chk("last_raddr_b", 96'(raddr_b0), 96'(NREG - 1));
      end
      if (c == NR + 2) begin
        chk("last_waddr_b", 96'(waddr_b0), 96'(NREG - 1));
        chk("last_wdata_b", 96'(wdata_b0), 96'(32'hA5A5_0000 + 32'(NREG - 1)));
        chk("drain_no_read", 96'(backup0), 96'd0);
      end
      if (c == NR + 3) chk("done_pulse", 96'(done0), 96'd1);
      if (c == NR + 4) chk("idle_after", 96'({busy0, done0}), 96'd0);
    end

    // start_i held for 40 cycles
    #1;
    start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) chk("hold_setback_c1", 96'(setback0), 96'd1);
      if (c == NR + 3) chk("hold_done", 96'(done0), 96'd1);
      if (c == NR + 4) chk("hold_busy_drop", 96'(busy0), 96'd0);
      if (c == NR + 5) chk("hold_second_seq", 96'(setback0), 96'd1);
    end
    start = 1'b0;
    repeat (NR + 8) @(posedge clk);

    // Reset in the middle of a sequence
    #2;
    fill_mem(1'b0);
    start = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) start = 1'b0;
    end
    chk("pre_reset_busy", 96'(busy0), 96'd1);
    rst_n = 1'b0;
    #1;
    chk("midreset_dut0", obs0, 96'd0);
    chk("midreset_dut1", obs1, 96'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    we_seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (we_a0 || we_b0 || we_a1 || we_b1) we_seen++;
    end
    chk("no_we_after_reset", 96'(we_seen), 96'd0);

    // Randomized starts, resets and golden-copy contents
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #2;
      if (k == 0 && $urandom_range(0, 15) == 0) fill_mem(1'b0);
      start = ($urandom_range(0, 7) == 0);
      rst_n = ($urandom_range(0, 199) != 0);
    end
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    checking = 1'b0;

    $display("[TB] %0d tests run, %0d failed", num_tests, num_fail);
    $finish;
  end

endmodule
